// File: rtl/dpram_seq_ctrl.sv
// dpram_seq_ctrl
// Block-operation sequencer for a dual-port synchronous RAM (2^ADDR_W x DATA_W).
// It takes one command at a time (FILL, ADD constant, COPY, SUM) over an address
// range and processes one element per clock with no stalls.
//   Port A issues the reads (or the writes for FILL).
//   Port B does the write-back one cycle after each read (ADD/COPY).
//
// Ports
//   clk, reset        clock; synchronous active-high reset
//   cmd_valid/ready   command handshake; see below
//   cmd_op            0 FILL, 1 ADD, 2 COPY, 3 SUM
//   cmd_base          first source/target address
//   cmd_len           element count (0 = empty operation)
//   cmd_arg           FILL value / ADD constant / COPY destination base
//   busy              high in RUN, DRAIN and DONE
//   done              one-cycle pulse at the end of every accepted command
//   result            SUM total; held until the next SUM updates it
//   addr_a/din_a/wen_a, addr_b/din_b/wen_b   RAM port drives (0 when idle)
//   dout_a, dout_b    RAM read data, valid the cycle after the address
//   dbg_state         current FSM state, for checkers
//
// Handshake: a command transfers on the rising edge where cmd_valid && cmd_ready.
// cmd_ready is high only in IDLE. The command fields are sampled on that edge
// only, so the producer may change them freely while busy is high.
module dpram_seq_ctrl #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_base,
    input  logic [ADDR_W-1:0] cmd_len,
    input  logic [DATA_W-1:0] cmd_arg,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic [ADDR_W-1:0] addr_a,
    output logic [DATA_W-1:0] din_a,
    output logic              wen_a,
    output logic [ADDR_W-1:0] addr_b,
    output logic [DATA_W-1:0] din_b,
    output logic              wen_b,
    input  logic [DATA_W-1:0] dout_a,
    input  logic [DATA_W-1:0] dout_b,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [1:0] OP_FILL = 2'd0;
    localparam logic [1:0] OP_ADD  = 2'd1;
    localparam logic [1:0] OP_COPY = 2'd2;
    localparam logic [1:0] OP_SUM  = 2'd3;

    localparam logic [ADDR_W-1:0] ONE_A = 1;

    state_t            state;
    logic [1:0]        op_q;
    logic [DATA_W-1:0] arg_q;
    logic [ADDR_W-1:0] cnt_q;      // reads still to issue after the current one
    logic [ADDR_W-1:0] dst_q;      // next COPY destination address

    logic [ADDR_W-1:0] a_addr_q;
    logic [DATA_W-1:0] a_din_q;
    logic              a_wen_q;

    logic              pend_q;     // read data from last cycle arrives this cycle
    logic [ADDR_W-1:0] b_addr_q;
    logic              b_wen_q;

    logic              fwd_q;      // last cycle's read hit the port B write
    logic [DATA_W-1:0] fwd_data_q;

    logic [DATA_W-1:0] acc_q;
    logic [DATA_W-1:0] result_q;

    logic [DATA_W-1:0] rd_data;
    logic [DATA_W-1:0] b_data;
    logic              unused_bits;

    // The RAM returns old data when one port reads the address that the other
    // port writes in the same cycle. In that case the registered write data
    // replaces dout_a, so that overlapping copies behave like a sequential loop.
    assign rd_data = fwd_q ? fwd_data_q : dout_a;
    assign b_data  = (op_q == OP_ADD) ? (rd_data + arg_q) : rd_data;

    assign cmd_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);
    assign result    = result_q;
    assign dbg_state = state;

    // The write enables are gated by reset. A reset during an operation then
    // blocks the write that was already on the port in that cycle.
    assign addr_a = a_addr_q;
    assign din_a  = a_din_q;
    assign wen_a  = a_wen_q & ~reset;
    assign addr_b = b_addr_q;
    assign din_b  = b_wen_q ? b_data : '0;
    assign wen_b  = b_wen_q & ~reset;

    assign unused_bits = ^dout_b;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            op_q       <= OP_FILL;
            arg_q      <= '0;
            cnt_q      <= '0;
            dst_q      <= '0;
            a_addr_q   <= '0;
            a_din_q    <= '0;
            a_wen_q    <= 1'b0;
            pend_q     <= 1'b0;
            b_addr_q   <= '0;
            b_wen_q    <= 1'b0;
            fwd_q      <= 1'b0;
            fwd_data_q <= '0;
            acc_q      <= '0;
            result_q   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        op_q  <= cmd_op;
                        arg_q <= cmd_arg;
                        dst_q <= cmd_arg[ADDR_W-1:0];
                        acc_q <= '0;
                        if (cmd_len == '0) begin
                            state <= S_DONE;
                            if (cmd_op == OP_SUM) begin
                                result_q <= '0;
                            end
                        end else begin
                            state    <= S_RUN;
                            cnt_q    <= cmd_len - ONE_A;
                            a_addr_q <= cmd_base;
                            a_wen_q  <= (cmd_op == OP_FILL);
                            a_din_q  <= (cmd_op == OP_FILL) ? cmd_arg : '0;
                        end
                    end
                end

                S_RUN: begin
                    // Set up the write-back for the read issued in this cycle.
                    pend_q  <= (op_q != OP_FILL);
                    b_wen_q <= (op_q == OP_ADD) || (op_q == OP_COPY);
                    case (op_q)
                        OP_ADD:  b_addr_q <= a_addr_q;
                        OP_COPY: b_addr_q <= dst_q;
                        default: b_addr_q <= '0;
                    endcase
                    if (op_q == OP_COPY) begin
                        dst_q <= dst_q + ONE_A;
                    end
                    fwd_q      <= b_wen_q && (b_addr_q == a_addr_q);
                    fwd_data_q <= b_data;
                    if (pend_q) begin
                        acc_q <= acc_q + rd_data;
                    end

                    if (cnt_q == '0) begin
                        state    <= (op_q == OP_FILL) ? S_DONE : S_DRAIN;
                        a_addr_q <= '0;
                        a_din_q  <= '0;
                        a_wen_q  <= 1'b0;
                    end else begin
                        cnt_q    <= cnt_q - ONE_A;
                        a_addr_q <= a_addr_q + ONE_A;
                    end
                end

                S_DRAIN: begin
                    // The last read's data is consumed in this cycle.
                    pend_q   <= 1'b0;
                    b_wen_q  <= 1'b0;
                    b_addr_q <= '0;
                    fwd_q    <= 1'b0;
                    acc_q    <= acc_q + rd_data;
                    if (op_q == OP_SUM) begin
                        result_q <= acc_q + rd_data;
                    end
                    state <= S_DONE;
                end

                S_DONE: begin
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dpram_seq_ctrl.sv
// Directed testbench for dpram_seq_ctrl, built around a behavioural dual-port RAM.
// The RAM returns old data on a read that collides with a write in the same cycle.
module tb_dpram_seq_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'd0;
    logic [9:0]  cmd_base = '0;
    logic [9:0]  cmd_len = '0;
    logic [15:0] cmd_arg = '0;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic [9:0]  addr_a;
    logic [15:0] din_a;
    logic        wen_a;
    logic [9:0]  addr_b;
    logic [15:0] din_b;
    logic        wen_b;
    logic [15:0] dout_a;
    logic [15:0] dout_b;
    logic [1:0]  dbg_state;

    logic [15:0] mem [0:1023];

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    dpram_seq_ctrl dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_base(cmd_base), .cmd_len(cmd_len), .cmd_arg(cmd_arg),
        .busy(busy), .done(done), .result(result),
        .addr_a(addr_a), .din_a(din_a), .wen_a(wen_a),
        .addr_b(addr_b), .din_b(din_b), .wen_b(wen_b),
        .dout_a(dout_a), .dout_b(dout_b), .dbg_state(dbg_state)
    );

    always @(posedge clk) begin
        dout_a <= mem[addr_a];
        dout_b <= mem[addr_b];
        if (wen_a) mem[addr_a] <= din_a;
        if (wen_b) mem[addr_b] <= din_b;
    end

    // Issue one command from IDLE. It reports the cycle in which done appeared
    // (0 on timeout), whether any write was seen, and result in the done cycle.
    task automatic run_cmd(input logic [1:0] op, input logic [9:0] base,
                           input logic [9:0] len, input logic [15:0] arg,
                           output int done_cyc, output logic saw_wen,
                           output logic [15:0] res);
        cmd_op = op; cmd_base = base; cmd_len = len; cmd_arg = arg;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        done_cyc = 0; saw_wen = 1'b0; res = '0;
        for (int c = 1; c <= 2000; c++) begin
            if (wen_a || wen_b) saw_wen = 1'b1;
            if (done) begin
                done_cyc = c;
                res = result;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
    endtask

    task automatic zero_mem();
        for (int i = 0; i < 1024; i++) mem[i] <= 16'h0000;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        n_checks++;
        if ({cmd_ready, busy, done, wen_a, wen_b} !== 5'b10000) begin
            n_fail++; $display("FAIL reset_flags: got %b want 10000", {cmd_ready, busy, done, wen_a, wen_b});
        end
        n_checks++;
        if ({result, addr_a, din_a, addr_b, din_b} !== 62'd0) begin
            n_fail++; $display("FAIL reset_values: result=%h addr_a=%h din_a=%h addr_b=%h din_b=%h, want all 0",
                               result, addr_a, din_a, addr_b, din_b);
        end
        reset = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (cmd_ready !== 1'b1) begin
            n_fail++; $display("FAIL ready_after_reset: got %b want 1", cmd_ready);
        end
    endtask

    task automatic test_fill();
        int dc; logic sw; logic [15:0] r;
        zero_mem();
        run_cmd(2'd0, 10'd0, 10'd11, 16'd5, dc, sw, r);
        n_checks++;
        if (dc !== 12) begin n_fail++; $display("FAIL fill_done_cycle: got %0d want 12", dc); end
        for (int i = 0; i < 11; i++) begin
            n_checks++;
            if (mem[i] !== 16'd5) begin n_fail++; $display("FAIL fill_mem[%0d]: got %h want 0005", i, mem[i]); end
        end
        n_checks++;
        if (mem[11] !== 16'd0) begin n_fail++; $display("FAIL fill_mem[11]: got %h want 0000", mem[11]); end
    endtask

    task automatic test_add();
        int dc; logic sw; logic [15:0] r;
        run_cmd(2'd1, 10'd0, 10'd11, 16'd1, dc, sw, r);
        n_checks++;
        if (dc !== 13) begin n_fail++; $display("FAIL add_done_cycle: got %0d want 13", dc); end
        for (int i = 0; i < 11; i++) begin
            n_checks++;
            if (mem[i] !== 16'd6) begin n_fail++; $display("FAIL add_mem[%0d]: got %h want 0006", i, mem[i]); end
        end
        n_checks++;
        if (mem[11] !== 16'd0) begin n_fail++; $display("FAIL add_mem[11]: got %h want 0000", mem[11]); end
    endtask

    task automatic test_sum();
        int dc; logic sw; logic [15:0] r;
        run_cmd(2'd3, 10'd0, 10'd11, 16'h1234, dc, sw, r);
        n_checks++;
        if (dc !== 13) begin n_fail++; $display("FAIL sum_done_cycle: got %0d want 13", dc); end
        n_checks++;
        if (r !== 16'd66) begin n_fail++; $display("FAIL sum_result: got %0d want 66", r); end
        n_checks++;
        if (sw !== 1'b0) begin n_fail++; $display("FAIL sum_no_write: got %b want 0", sw); end
        n_checks++;
        if (result !== 16'd66) begin n_fail++; $display("FAIL sum_result_held: got %0d want 66", result); end
    endtask

    task automatic test_copy();
        int dc; logic sw; logic [15:0] r;
        logic [15:0] exp_o [0:4];
        for (int i = 0; i < 4; i++) mem[100+i] <= 16'(i + 1);
        mem[104] <= 16'd0;
        #1;
        run_cmd(2'd2, 10'd100, 10'd4, 16'd200, dc, sw, r);
        n_checks++;
        if (dc !== 6) begin n_fail++; $display("FAIL copy_done_cycle: got %0d want 6", dc); end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (mem[200+i] !== 16'(i + 1)) begin
                n_fail++; $display("FAIL copy_mem[%0d]: got %h want %h", 200+i, mem[200+i], 16'(i + 1));
            end
        end
        n_checks++;
        if (result !== 16'd66) begin n_fail++; $display("FAIL copy_result_unchanged: got %0d want 66", result); end
        // Overlapping copy forward by one: the loop smears mem[100] upward.
        exp_o = '{16'd1, 16'd1, 16'd1, 16'd1, 16'd1};
        run_cmd(2'd2, 10'd100, 10'd4, 16'd101, dc, sw, r);
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (mem[100+i] !== exp_o[i]) begin
                n_fail++; $display("FAIL copy_overlap_mem[%0d]: got %h want %h", 100+i, mem[100+i], exp_o[i]);
            end
        end
    endtask

    task automatic test_wrap();
        int dc; logic sw; logic [15:0] r;
        run_cmd(2'd0, 10'd1020, 10'd8, 16'hA5A5, dc, sw, r);
        n_checks++;
        if (dc !== 9) begin n_fail++; $display("FAIL wrap_done_cycle: got %0d want 9", dc); end
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (mem[(1020+i) % 1024] !== 16'hA5A5) begin
                n_fail++; $display("FAIL wrap_mem[%0d]: got %h want a5a5", (1020+i) % 1024, mem[(1020+i) % 1024]);
            end
        end
        n_checks++;
        if (mem[4] !== 16'd6) begin n_fail++; $display("FAIL wrap_mem[4]: got %h want 0006", mem[4]); end
        mem[600] <= 16'hFFFF; mem[601] <= 16'hFFFF;
        #1;
        run_cmd(2'd3, 10'd600, 10'd2, 16'd0, dc, sw, r);
        n_checks++;
        if (r !== 16'hFFFE) begin n_fail++; $display("FAIL sum_wrap_result: got %h want fffe", r); end
        n_checks++;
        if (dc !== 4) begin n_fail++; $display("FAIL sum_wrap_done_cycle: got %0d want 4", dc); end
    endtask

    task automatic test_len0();
        int dc; logic sw; logic [15:0] r;
        run_cmd(2'd0, 10'd50, 10'd0, 16'h7777, dc, sw, r);
        n_checks++;
        if (dc !== 1) begin n_fail++; $display("FAIL len0_done_cycle: got %0d want 1", dc); end
        n_checks++;
        if (sw !== 1'b0) begin n_fail++; $display("FAIL len0_no_write: got %b want 0", sw); end
        n_checks++;
        if (mem[50] !== 16'd0) begin n_fail++; $display("FAIL len0_mem[50]: got %h want 0000", mem[50]); end
        run_cmd(2'd3, 10'd0, 10'd0, 16'd0, dc, sw, r);
        n_checks++;
        if (r !== 16'd0) begin n_fail++; $display("FAIL len0_sum_result: got %h want 0000", r); end
    endtask

    task automatic test_back_to_back();
        int dc;
        cmd_op = 2'd0; cmd_base = 10'd300; cmd_len = 10'd2; cmd_arg = 16'd7;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        // Second command presented while busy; the first must keep its fields.
        cmd_base = 10'd302; cmd_len = 10'd1; cmd_arg = 16'd8;
        dc = 0;
        for (int c = 1; c <= 100; c++) begin
            if (done) begin dc = c; break; end
            @(posedge clk); #1;
        end
        n_checks++;
        if (dc !== 3) begin n_fail++; $display("FAIL b2b_first_done: got %0d want 3", dc); end
        @(posedge clk); #1;
        n_checks++;
        if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_after_done: got %b want 1", cmd_ready); end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        n_checks++;
        if ({wen_a, addr_a, din_a} !== {1'b1, 10'd302, 16'd8}) begin
            n_fail++; $display("FAIL b2b_second_issue: got wen=%b addr=%0d din=%h want 1/302/0008", wen_a, addr_a, din_a);
        end
        for (int c = 0; c < 10; c++) begin @(posedge clk); #1; end
        n_checks++;
        if ({mem[300], mem[301], mem[302]} !== {16'd7, 16'd7, 16'd8}) begin
            n_fail++; $display("FAIL b2b_mem: got %h %h %h want 0007 0007 0008", mem[300], mem[301], mem[302]);
        end
    endtask

    task automatic test_reset_mid();
        cmd_op = 2'd0; cmd_base = 10'd500; cmd_len = 10'd10; cmd_arg = 16'd9;
        cmd_valid = 1'b1;
        @(posedge clk); #1;           // cycle 1
        cmd_valid = 1'b0;
        @(posedge clk); #1;           // cycle 2
        @(posedge clk); #1;           // cycle 3
        reset = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if ({cmd_ready, busy, done, wen_a, wen_b} !== 5'b10000) begin
            n_fail++; $display("FAIL midreset_flags: got %b want 10000", {cmd_ready, busy, done, wen_a, wen_b});
        end
        n_checks++;
        if ({result, addr_a, din_a, addr_b, din_b} !== 62'd0) begin
            n_fail++; $display("FAIL midreset_values: result=%h addr_a=%h din_a=%h, want 0", result, addr_a, din_a);
        end
        reset = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if ({mem[500], mem[501], mem[502], mem[503]} !== {16'd9, 16'd9, 16'd0, 16'd0}) begin
            n_fail++; $display("FAIL midreset_mem: got %h %h %h %h want 0009 0009 0000 0000",
                               mem[500], mem[501], mem[502], mem[503]);
        end
    endtask

    initial begin
        zero_mem();
        test_reset();
        test_fill();
        test_add();
        test_sum();
        test_copy();
        test_wrap();
        test_len0();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
